// File: rtl/wt_cache_subsystem.sv
// Direct-mapped write-through, no-write-allocate data cache with controller FSM,
// behavioural backing memory of configurable latency and read hit/miss counters.
module wt_cache_subsystem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int INDEX_W     = 5,
  parameter int OFFSET_W    = 2,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] WordAddress,
  input  logic [DATA_W-1:0] DataIn,
  output logic              Stall,
  output logic [DATA_W-1:0] DataOut,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, WR_DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [LINES-1:0]    valid_q;
  logic                refill_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_data_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES][WORDS];
  logic [DATA_W-1:0]   mem_q  [DEPTH];

  logic [OFFSET_W-1:0] req_off, lat_off;
  logic [INDEX_W-1:0]  req_idx, lat_idx;
  logic [TAG_W-1:0]    req_tag, lat_tag;
  logic                req_hit, lat_hit, is_rd, last_beat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req_off   = WordAddress[OFFSET_W-1:0];
  assign req_idx   = WordAddress[OFFSET_W +: INDEX_W];
  assign req_tag   = WordAddress[ADDR_W-1 -: TAG_W];
  assign lat_off   = lat_addr_q[OFFSET_W-1:0];
  assign lat_idx   = lat_addr_q[OFFSET_W +: INDEX_W];
  assign lat_tag   = lat_addr_q[ADDR_W-1 -: TAG_W];
  assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit   = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
  assign is_rd     = MemRead && !MemWrite;
  assign last_beat = (cnt_q == CNT_LAST);

  // Stall is combinational so a miss or write is held from its detect cycle
  always_comb begin
    Stall = 1'b0;
    case (state_q)
      IDLE:             Stall = MemWrite || (MemRead && !req_hit);
      RD_WAIT, WR_WAIT: Stall = 1'b1;
      default:          Stall = 1'b0;
    endcase
  end

  assign DataOut = (state_q == IDLE && is_rd && req_hit) ? data_q[req_idx][req_off] : '0;

  // Controller FSM and statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      refill_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          refill_q <= 1'b0;
          if (MemWrite) begin
            cnt_q   <= '0;
            state_q <= WR_WAIT;
          end else if (MemRead) begin
            if (req_hit) begin
              if (!refill_q) hit_count <= sat_inc(hit_count);
            end else begin
              miss_count <= sat_inc(miss_count);
              cnt_q      <= '0;
              state_q    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (last_beat) begin
            valid_q[lat_idx] <= 1'b1;
            refill_q         <= 1'b1;
            state_q          <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR_WAIT: begin
          if (last_beat) state_q <= WR_DONE;
          else           cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Backing memory: cleared by reset, written at the final write beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == WR_WAIT && last_beat) begin
      mem_q[lat_addr_q] <= lat_data_q;
    end
  end

  // Request latch and cache arrays; state gating keeps reset from leaking a fill
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      lat_addr_q <= WordAddress;
      lat_data_q <= DataIn;
    end
    if (state_q == RD_WAIT && last_beat) begin
      tag_q[lat_idx] <= lat_tag;
      for (int w = 0; w < WORDS; w++)
        data_q[lat_idx][w] <= mem_q[{lat_addr_q[ADDR_W-1:OFFSET_W], OFFSET_W'(w)}];
    end
    if (state_q == WR_WAIT && last_beat && lat_hit)
      data_q[lat_idx][lat_off] <= lat_data_q;
  end

endmodule

// File: tb/tb_wt_cache_subsystem.sv
// Directed bench for wt_cache_subsystem: stall timing, data, counters, reset abort,
// plus a 2-bit-counter instance run in lockstep to exercise saturation.
module tb_wt_cache_subsystem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [9:0]  WordAddress;
  logic [31:0] DataIn;
  logic        Stall, Stall2;
  logic [31:0] DataOut, DataOut2;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  hit2, miss2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wt_cache_subsystem #(.MEM_LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .WordAddress(WordAddress), .DataIn(DataIn), .Stall(Stall), .DataOut(DataOut),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  wt_cache_subsystem #(.MEM_LATENCY(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .WordAddress(WordAddress), .DataIn(DataIn), .Stall(Stall2), .DataOut(DataOut2),
    .hit_count(hit2), .miss_count(miss2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns stall cycles and the data on the release cycle
  task automatic rd(input logic [9:0] a, output int stalls, output logic [31:0] d);
    MemRead = 1'b1; MemWrite = 1'b0; WordAddress = a;
    stalls = 0; d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Stall) begin
        d = DataOut;
        break;
      end
      stalls++;
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] v, input logic both,
                    output int stalls, output logic [31:0] d_stall, output logic [31:0] d_done);
    MemWrite = 1'b1; MemRead = both; WordAddress = a; DataIn = v;
    stalls = 0; d_stall = '0; d_done = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Stall) begin
        d_done = DataOut;
        break;
      end
      if (stalls == 0) d_stall = DataOut;
      stalls++;
    end
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    chk("rst_stall",   {31'h0, Stall},      32'h0);
    chk("rst_dataout", DataOut,              32'h0);
    chk("rst_hits",    {16'h0, hit_count},   32'h0);
    chk("rst_misses",  {16'h0, miss_count},  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int          st;
    logic [31:0] d, ds, dd;

    MemRead = 1'b0; MemWrite = 1'b0; WordAddress = '0; DataIn = '0;
    do_reset();

    // Cold read miss
    rd(10'h005, st, d);
    chk("rd005_stall", st, 32'd5);
    chk("rd005_data",  d,  32'h0);
    chk("rd005_miss",  {16'h0, miss_count}, 32'd1);
    chk("rd005_hit",   {16'h0, hit_count},  32'd0);

    // Write miss (no allocate), then read it back through a refill
    wr(10'h010, 32'hDEAD_BEEF, 1'b0, st, ds, dd);
    chk("wr010_stall", st, 32'd5);
    chk("wr010_done",  dd, 32'h0);
    rd(10'h010, st, d);
    chk("rd010_stall", st, 32'd5);
    chk("rd010_data",  d,  32'hDEAD_BEEF);
    chk("rd010_hit",   {16'h0, hit_count}, 32'd0);
    rd(10'h011, st, d);
    chk("rd011_stall", st, 32'd0);
    chk("rd011_data",  d,  32'h0);
    chk("rd011_hit",   {16'h0, hit_count}, 32'd1);

    // Write hit updates the cached word
    wr(10'h012, 32'h1234_5678, 1'b0, st, ds, dd);
    chk("wr012_stall", st, 32'd5);
    rd(10'h012, st, d);
    chk("rd012_stall", st, 32'd0);
    chk("rd012_data",  d,  32'h1234_5678);
    chk("rd012_miss",  {16'h0, miss_count}, 32'd2);
    chk("rd012_hit",   {16'h0, hit_count},  32'd2);
    chk("sat_hit2",    {30'h0, hit2},       32'd2);

    // Reset two cycles into a read miss
    MemRead = 1'b1; WordAddress = 10'h040;
    @(posedge clk); @(posedge clk); #1;
    chk("abort_pre_stall", {31'h0, Stall}, 32'h1);
    reset_n = 1'b0; MemRead = 1'b0;
    #1;
    chk("abort_stall", {31'h0, Stall},      32'h0);
    chk("abort_miss",  {16'h0, miss_count}, 32'd0);
    chk("abort_hit",   {16'h0, hit_count},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(10'h040, st, d);
    chk("reread_stall", st, 32'd5);
    chk("reread_miss",  {16'h0, miss_count}, 32'd1);

    // Conflict misses on index 4; reset also cleared backing memory
    do_reset();
    rd(10'h010, st, d);
    chk("cf1_stall", st, 32'd5);
    chk("cf1_data",  d,  32'h0);
    rd(10'h090, st, d);
    chk("cf2_stall", st, 32'd5);
    rd(10'h010, st, d);
    chk("cf3_stall", st, 32'd5);
    chk("cf_miss",   {16'h0, miss_count}, 32'd3);

    // Simultaneous read+write executes as a write
    wr(10'h020, 32'hA5A5_A5A5, 1'b1, st, ds, dd);
    chk("rw_stall",      st, 32'd5);
    chk("rw_data_stall", ds, 32'h0);
    chk("rw_data_done",  dd, 32'h0);
    chk("rw_miss",       {16'h0, miss_count}, 32'd3);
    chk("rw_hit",        {16'h0, hit_count},  32'd0);
    rd(10'h020, st, d);
    chk("rd020_stall", st, 32'd5);
    chk("rd020_data",  d,  32'hA5A5_A5A5);
    chk("rd020_miss",  {16'h0, miss_count}, 32'd4);
    chk("sat_miss2",   {30'h0, miss2},      32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
